// File: rtl/adc_spi_if.sv
// Four-wire serial ADC link between the IMU controller (initiator) and the emulated ADC.
// The initiator drives chip select, serial clock and address data; the ADC drives DOUT.
interface adc_spi_if;
    logic adc_cs_n;
    logic adc_sclk;
    logic adc_saddr;
    logic adc_sdat;

    modport master (
        output adc_cs_n,
        output adc_sclk,
        output adc_saddr,
        input  adc_sdat
    );

    modport slave (
        input  adc_cs_n,
        input  adc_sclk,
        input  adc_saddr,
        output adc_sdat
    );
endinterface

// File: rtl/adc_spi_responder.sv
// Emulates an 8-channel 12-bit serial ADC on the responder side of the link.
// SPI lines are oversampled on clk; every returned word is the channel addressed in the previous frame.
module adc_spi_responder #(
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    adc_spi_if.slave                 spi,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     busy,
    output logic                     frame_done,
    output logic [2:0]               frame_addr,
    output logic [15:0]              frame_count
);

    typedef enum logic {
        StIdle,
        StActive
    } state_e;

    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] din_sync_q;

    logic cs_s;
    logic sclk_s;
    logic din_s;
    logic sclk_rise;
    logic sclk_fall;

    state_e      state_q;
    logic        cs_prev_q;
    logic        sclk_prev_q;
    logic [3:0]  rise_cnt_q;
    logic [2:0]  addr_sr_q;
    logic [2:0]  next_addr_q;
    logic [15:0] tx_sr_q;
    logic        sdat_q;
    logic        busy_q;
    logic        frame_done_q;
    logic [2:0]  frame_addr_q;
    logic [15:0] frame_count_q;
    logic [15:0] sel_word;

    // Synchronizers reset low so a select already in progress at reset never looks like a new one.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync_q   <= '0;
            sclk_sync_q <= '0;
            din_sync_q  <= '0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi.adc_cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.adc_sclk};
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], spi.adc_saddr};
        end
    end

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign din_s     = din_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    // Addresses at or beyond NUM_CH fall through to the all-zero default.
    always_comb begin
        sel_word = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (next_addr_q == 3'(k)) begin
                sel_word = 16'(ch_data[k*DATA_W +: DATA_W]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cs_prev_q     <= 1'b0;
            sclk_prev_q   <= 1'b0;
            rise_cnt_q    <= '0;
            addr_sr_q     <= '0;
            next_addr_q   <= '0;
            tx_sr_q       <= '0;
            sdat_q        <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_addr_q  <= '0;
            frame_count_q <= '0;
        end else begin
            cs_prev_q    <= cs_s;
            sclk_prev_q  <= sclk_s;
            frame_done_q <= 1'b0;
            if (cs_s) begin
                // Deselect also aborts any partial frame; frame_count is left alone.
                state_q     <= StIdle;
                rise_cnt_q  <= '0;
                addr_sr_q   <= '0;
                next_addr_q <= '0;
                tx_sr_q     <= '0;
                sdat_q      <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (cs_prev_q) begin
                            state_q <= StActive;
                            busy_q  <= 1'b1;
                            tx_sr_q <= sel_word;
                            sdat_q  <= sel_word[15];
                        end
                    end
                    StActive: begin
                        if (sclk_rise) begin
                            if (rise_cnt_q inside {4'd2, 4'd3, 4'd4}) begin
                                addr_sr_q <= {addr_sr_q[1:0], din_s};
                            end
                            rise_cnt_q <= rise_cnt_q + 4'd1;
                            if (rise_cnt_q == 4'd15) begin
                                next_addr_q   <= addr_sr_q;
                                frame_addr_q  <= addr_sr_q;
                                frame_done_q  <= 1'b1;
                                frame_count_q <= frame_count_q + 16'd1;
                            end
                        end else if (sclk_fall) begin
                            // A falling edge with no rising edge yet in this frame starts a new word.
                            if (rise_cnt_q == 4'd0) begin
                                tx_sr_q <= sel_word;
                                sdat_q  <= sel_word[15];
                            end else begin
                                tx_sr_q <= {tx_sr_q[14:0], 1'b0};
                                sdat_q  <= tx_sr_q[14];
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign spi.adc_sdat = sdat_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign frame_addr   = frame_addr_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Randomized bench for adc_spi_responder: an SPI initiator model plus a frame-level reference model.
module tb_adc_spi_responder;
    localparam int NUM_CH = 8;
    localparam int DATA_W = 12;

    logic                     clk;
    logic                     reset;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic                     busy;
    logic                     frame_done;
    logic [2:0]               frame_addr;
    logic [15:0]              frame_count;

    adc_spi_if bus ();

    adc_spi_responder #(
        .NUM_CH      (NUM_CH),
        .DATA_W      (DATA_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .spi         (bus),
        .ch_data     (ch_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_addr  (frame_addr),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int half_clks = 5;

    // Reference model: channel table, address to return next, frame counter.
    int ch_arr [NUM_CH];
    int model_next;
    int model_count;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_ch();
        for (int k = 0; k < NUM_CH; k++) ch_data[k*DATA_W +: DATA_W] = DATA_W'(ch_arr[k]);
    endtask

    function automatic logic [15:0] model_word();
        if (model_next < NUM_CH) return 16'(ch_arr[model_next]);
        return 16'h0000;
    endfunction

    task automatic select();
        bus.adc_cs_n = 1'b0;
        wait_clk(6);
    endtask

    task automatic deselect();
        bus.adc_cs_n = 1'b1;
        wait_clk(6);
        model_next = 0;
    endtask

    // Address goes out in bits 13:11 of the DIN word; DOUT is read at each rising edge.
    task automatic run_frame(input int addr, input int nrise, output logic [15:0] word);
        logic [15:0] din_word;
        din_word = 16'(addr) << 11;
        word = '0;
        for (int k = 0; k < nrise; k++) begin
            bus.adc_saddr = din_word[15-k];
            bus.adc_sclk  = 1'b0;
            wait_clk(half_clks);
            bus.adc_sclk  = 1'b1;
            word = {word[14:0], bus.adc_sdat};
            wait_clk(half_clks);
        end
    endtask

    // One complete frame checked against the model.
    task automatic model_frame(input string tag, input int addr);
        logic [15:0] w;
        logic [15:0] exp_w;
        int d0;
        d0 = done_cnt;
        exp_w = model_word();
        run_frame(addr, 16, w);
        model_next = addr;
        model_count = (model_count + 1) % 65536;
        check({tag, "_word"}, 32'(w), 32'(exp_w));
        check({tag, "_addr"}, 32'(frame_addr), 32'(addr));
        check({tag, "_count"}, 32'(frame_count), 32'(model_count));
        check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        logic [15:0] w;
        int d0;

        // Reset with cs_n low and sclk toggling.
        reset = 1'b1;
        bus.adc_cs_n = 1'b0;
        bus.adc_sclk = 1'b1;
        bus.adc_saddr = 1'b0;
        for (int k = 0; k < NUM_CH; k++) ch_arr[k] = 'hABC;
        apply_ch();
        model_next = 0;
        model_count = 0;
        wait_clk(2);
        run_frame(1, 4, w);
        reset = 1'b0;
        wait_clk(1);
        check("rst_sdat", 32'(bus.adc_sdat), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(frame_count), 32'd0);
        run_frame(1, 16, w);
        run_frame(2, 16, w);
        check("rst_ignored_done", 32'(done_cnt), 32'd0);
        check("rst_ignored_word", 32'(w), 32'd0);
        check("rst_ignored_busy", 32'(busy), 32'd0);
        deselect();

        // Single frame.
        ch_arr[0] = 'h5A3;
        apply_ch();
        select();
        check("sel_busy", 32'(busy), 32'd1);
        model_frame("single", 3);
        deselect();
        check("desel_busy", 32'(busy), 32'd0);
        check("desel_count_hold", 32'(frame_count), 32'd1);

        // Reset mid-frame, then the rest of that frame must be ignored.
        select();
        d0 = done_cnt;
        run_frame(4, 6, w);
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sdat", 32'(bus.adc_sdat), 32'd0);
        check("midrst_count", 32'(frame_count), 32'd0);
        run_frame(4, 10, w);
        check("midrst_done", 32'(done_cnt - d0), 32'd0);
        deselect();
        model_count = 0;

        // Pipelined addressing over back-to-back frames.
        for (int k = 0; k < NUM_CH; k++) ch_arr[k] = 0;
        ch_arr[3] = 'h123;
        ch_arr[6] = 'hFED;
        apply_ch();
        select();
        model_frame("pipe0", 3);
        model_frame("pipe1", 6);
        model_frame("pipe2", 0);
        deselect();

        // Abort after 9 rising edges carrying address 5.
        ch_arr[0] = 'h0AA;
        ch_arr[5] = 'h555;
        apply_ch();
        select();
        d0 = done_cnt;
        run_frame(5, 9, w);
        deselect();
        check("abort_done", 32'(done_cnt - d0), 32'd0);
        check("abort_count", 32'(frame_count), 32'(model_count));
        select();
        model_frame("after_abort", 2);
        deselect();

        // Tight timing with random data, addresses and occasional deselects.
        half_clks = 4;
        select();
        for (int f = 0; f < 300; f++) begin
            for (int k = 0; k < NUM_CH; k++) ch_arr[k] = int'($urandom_range(0, 4095));
            apply_ch();
            model_frame("rand", int'($urandom_range(0, 7)));
            if ($urandom_range(0, 9) == 0) begin
                deselect();
                select();
            end
        end
        deselect();
        half_clks = 5;

        // Counter wrap from a preloaded 0xFFFF.
        force dut.frame_count_q = 16'hFFFF;
        wait_clk(1);
        release dut.frame_count_q;
        wait_clk(2);
        model_count = 'hFFFF;
        check("wrap_preload", 32'(frame_count), 32'hFFFF);
        select();
        model_frame("wrap", 1);
        check("wrap_zero", 32'(frame_count), 32'h0000);
        deselect();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
